// File: rtl/bell_pkg.sv
// Shared definitions for the alarm/chime bell scheduler.
// State encoding, counter widths and default timing parameters.
package bell_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RING   = 2'd1,
        ST_SNOOZE = 2'd2,
        ST_CHIME  = 2'd3
    } bellState_t;

    localparam int RING_SEC_DEF   = 60;
    localparam int SNOOZE_SEC_DEF = 300;
    localparam int MAX_SNOOZE_DEF = 3;

    localparam int RING_W = 6;
    localparam int SNZ_W  = 9;

    function automatic logic bcdIs(
        input logic [3:0] hi,
        input logic [3:0] lo,
        input logic [3:0] wantHi,
        input logic [3:0] wantLo
    );
        return (hi == wantHi) && (lo == wantLo);
    endfunction

endpackage

// File: rtl/bell_sec_timer.sv
// Seconds up-counter: advances on tick, clears on demand,
// and holds at its terminal count with done raised.
module bell_sec_timer #(
    parameter int W    = 6,
    parameter int TERM = 59
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         tick,
    output logic [W-1:0] count,
    output logic         done
);

    assign done = (count == W'(TERM));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (tick && !done) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/bell_scheduler.sv
// Alarm bell with ring/snooze sequencing and an hourly chime
// in the last ten seconds of each hour.
module bell_scheduler
    import bell_pkg::*;
#(
    parameter int RING_SEC   = RING_SEC_DEF,
    parameter int SNOOZE_SEC = SNOOZE_SEC_DEF,
    parameter int MAX_SNOOZE = MAX_SNOOZE_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       alarm_en,
    input  logic       chime_en,
    input  logic       alarm_match,
    input  logic       snooze_key,
    input  logic       stop_key,
    input  logic [3:0] m_cntH,
    input  logic [3:0] m_cntL,
    input  logic [3:0] s_cntH,
    input  logic [3:0] s_cntL,
    output logic       buzz,
    output logic       tone_sel,
    output logic [1:0] state
);

    bellState_t stQ;
    logic       matchQ;
    logic [1:0] snoozeCnt;

    logic [RING_W-1:0] ringCnt;
    logic [SNZ_W-1:0]  snzCnt;
    logic              ringDone;
    logic              snzDone;

    logic isIdle, isRing, isSnz, isChime;
    logic trigger, kill, snoozeGo;
    logic ringTick, snzTick, wake;
    logic chimeStart, chimeEnd, armed;
    logic ringClr;

    assign isIdle  = (stQ == ST_IDLE);
    assign isRing  = (stQ == ST_RING);
    assign isSnz   = (stQ == ST_SNOOZE);
    assign isChime = (stQ == ST_CHIME);

    assign trigger  = alarm_en && alarm_match && !matchQ;
    assign armed    = (isIdle || isChime) && trigger;
    assign kill     = (isRing || isSnz) && (!alarm_en || stop_key);
    assign snoozeGo = isRing && !kill && snooze_key
                    && (snoozeCnt < 2'(MAX_SNOOZE));

    // A key-driven move swallows a coincident tick.
    assign ringTick = isRing && !kill && !snoozeGo && tick_1hz;
    assign snzTick  = isSnz && !kill && tick_1hz;
    assign wake     = snzTick && snzDone;

    assign chimeStart = isIdle && !trigger && tick_1hz && chime_en
                      && bcdIs(m_cntH, m_cntL, 4'd5, 4'd9)
                      && bcdIs(s_cntH, s_cntL, 4'd5, 4'd0);
    assign chimeEnd   = isChime && !trigger
                      && (!chime_en
                          || bcdIs(s_cntH, s_cntL, 4'd0, 4'd0));

    assign ringClr = armed || wake;

    bell_sec_timer #(
        .W    (RING_W),
        .TERM (RING_SEC - 1)
    ) ringTimer (
        .clk   (clk),
        .rst   (rst),
        .clr   (ringClr),
        .tick  (ringTick),
        .count (ringCnt),
        .done  (ringDone)
    );

    bell_sec_timer #(
        .W    (SNZ_W),
        .TERM (SNOOZE_SEC - 1)
    ) snzTimer (
        .clk   (clk),
        .rst   (rst),
        .clr   (snoozeGo),
        .tick  (snzTick),
        .count (snzCnt),
        .done  (snzDone)
    );

    logic unusedBits;
    assign unusedBits = ^{snzCnt, ringCnt[RING_W-1:2]};

    assign state = stQ;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stQ       <= ST_IDLE;
            matchQ    <= 1'b0;
            snoozeCnt <= 2'd0;
            buzz      <= 1'b0;
            tone_sel  <= 1'b0;
        end else begin
            matchQ <= alarm_match;

            unique case (stQ)
                ST_RING: begin
                    buzz     <= ~ringCnt[0];
                    tone_sel <= ringCnt[1];
                end
                ST_CHIME: begin
                    buzz     <= (s_cntH == 4'd5) && s_cntL[0];
                    tone_sel <= (s_cntL == 4'd9);
                end
                default: begin
                    buzz     <= 1'b0;
                    tone_sel <= 1'b0;
                end
            endcase

            unique case (1'b1)
                kill: begin
                    stQ <= ST_IDLE;
                end
                armed: begin
                    stQ       <= ST_RING;
                    snoozeCnt <= 2'd0;
                end
                snoozeGo: begin
                    stQ       <= ST_SNOOZE;
                    snoozeCnt <= snoozeCnt + 2'd1;
                end
                (ringTick && ringDone): begin
                    stQ <= ST_IDLE;
                end
                wake: begin
                    stQ <= ST_RING;
                end
                chimeStart: begin
                    stQ <= ST_CHIME;
                end
                chimeEnd: begin
                    stQ <= ST_IDLE;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bell_scheduler.sv
// Bench for bell_scheduler: directed sequences, a chime vector
// table, and random traffic against a seconds-level model.
module tb_bell_scheduler;

    localparam int RS = 60;
    localparam int SS = 300;
    localparam int MS = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic tick = 1'b0;
    logic aEn = 1'b0;
    logic cEn = 1'b0;
    logic match = 1'b0;
    logic snz = 1'b0;
    logic stop = 1'b0;
    logic [3:0] mH = 4'd0;
    logic [3:0] mL = 4'd0;
    logic [3:0] sH = 4'd0;
    logic [3:0] sL = 4'd0;
    logic buzz;
    logic tone;
    logic [1:0] state;

    int checks = 0;
    int failures = 0;

    // Model: mode 0..3, elapsed seconds in ring/snooze, snoozes used.
    int mMode;
    int mRing;
    int mSnz;
    int mUsed;
    int mPrev;
    int mBuzz;
    int mTone;

    typedef struct {
        logic [3:0] sh;
        logic [3:0] sl;
        logic       tk;
        logic       ce;
        int         st;
        int         bz;
        int         tn;
    } vec_t;

    vec_t tbl[14];

    bell_scheduler #(
        .RING_SEC   (RS),
        .SNOOZE_SEC (SS),
        .MAX_SNOOZE (MS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tick_1hz    (tick),
        .alarm_en    (aEn),
        .chime_en    (cEn),
        .alarm_match (match),
        .snooze_key  (snz),
        .stop_key    (stop),
        .m_cntH      (mH),
        .m_cntL      (mL),
        .s_cntH      (sH),
        .s_cntL      (sL),
        .buzz        (buzz),
        .tone_sel    (tone),
        .state       (state)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic modelReset();
        mMode = 0;
        mRing = 0;
        mSnz  = 0;
        mUsed = 0;
        mPrev = 0;
        mBuzz = 0;
        mTone = 0;
    endtask

    task automatic modelStep();
        int trig;
        int nb;
        int nt;
        trig = (aEn && match && mPrev == 0) ? 1 : 0;
        nb = 0;
        nt = 0;
        if (mMode == 1) begin
            nb = (mRing % 2 == 0) ? 1 : 0;
            nt = (mRing / 2) % 2;
        end else if (mMode == 3) begin
            nb = (sH == 5 && sL % 2 == 1) ? 1 : 0;
            nt = (sL == 9) ? 1 : 0;
        end
        case (mMode)
            0: begin
                if (trig == 1) begin
                    mMode = 1; mRing = 0; mUsed = 0;
                end else if (tick && cEn && mH == 5 && mL == 9
                             && sH == 5 && sL == 0) begin
                    mMode = 3;
                end
            end
            1: begin
                if (!aEn || stop) begin
                    mMode = 0;
                end else if (snz && mUsed < MS) begin
                    mMode = 2; mUsed++; mSnz = 0;
                end else if (tick) begin
                    if (mRing == RS - 1) mMode = 0;
                    else mRing++;
                end
            end
            2: begin
                if (!aEn || stop) begin
                    mMode = 0;
                end else if (tick) begin
                    if (mSnz == SS - 1) begin
                        mMode = 1; mRing = 0;
                    end else begin
                        mSnz++;
                    end
                end
            end
            default: begin
                if (trig == 1) begin
                    mMode = 1; mRing = 0; mUsed = 0;
                end else if (!cEn || (sH == 0 && sL == 0)) begin
                    mMode = 0;
                end
            end
        endcase
        mPrev = match ? 1 : 0;
        mBuzz = nb;
        mTone = nt;
    endtask

    task automatic cyc();
        modelStep();
        @(posedge clk);
        #1;
        check("model", int'(state) * 4 + int'(buzz) * 2 + int'(tone),
              mMode * 4 + mBuzz * 2 + mTone);
    endtask

    task automatic tickCyc(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            cyc();
            tick = 1'b0;
        end
    endtask

    task automatic keyCyc(input logic s, input logic p, input logic t);
        snz = s;
        stop = p;
        tick = t;
        cyc();
        snz = 1'b0;
        stop = 1'b0;
        tick = 1'b0;
    endtask

    task automatic checkZero(input string name);
        check({name, ".state"}, int'(state), 0);
        check({name, ".buzz"}, int'(buzz), 0);
        check({name, ".tone"}, int'(tone), 0);
    endtask

    initial begin
        tbl[0]  = '{4'd5, 4'd0, 1'b0, 1'b1, 0, 0, 0};
        tbl[1]  = '{4'd5, 4'd0, 1'b1, 1'b0, 0, 0, 0};
        tbl[2]  = '{4'd5, 4'd0, 1'b1, 1'b1, 3, 0, 0};
        for (int s = 51; s <= 59; s++) begin
            tbl[s - 48] = '{4'd5, 4'(s - 50), 1'b1, 1'b1, 3,
                            s % 2, (s == 59) ? 1 : 0};
        end
        tbl[12] = '{4'd0, 4'd0, 1'b1, 1'b1, 0, 0, 0};
        tbl[13] = '{4'd0, 4'd0, 1'b1, 1'b1, 0, 0, 0};

        modelReset();
        #2 rst = 1'b1;
        #1 checkZero("reset");
        @(posedge clk);
        #1 rst = 1'b0;
        checkZero("reset.release");

        // Basic ring and timeout
        aEn = 1'b1;
        match = 1'b1;
        cyc();
        check("trigger.state", int'(state), 1);
        for (int k = 1; k <= RS; k++) begin
            tickCyc(1);
            if (k < RS) begin
                check("ring.buzz", int'(buzz), k % 2);
                check("ring.state", int'(state), 1);
            end
        end
        check("ring.timeout", int'(state), 0);
        cyc();
        check("timeout.buzz", int'(buzz), 0);
        match = 1'b0;
        cyc();

        // Snooze sequence: three accepted, fourth ignored
        match = 1'b1;
        cyc();
        match = 1'b0;
        check("trigger2.state", int'(state), 1);
        tickCyc(10);
        keyCyc(1'b1, 1'b0, 1'b1);
        check("snooze1.state", int'(state), 2);
        for (int n = 1; n <= 3; n++) begin
            tickCyc(SS - 1);
            check("snooze.hold", int'(state), 2);
            tickCyc(1);
            check("snooze.wake", int'(state), 1);
            if (n < 3) begin
                keyCyc(1'b1, 1'b0, 1'b0);
                check("snooze.again", int'(state), 2);
            end
        end
        keyCyc(1'b1, 1'b0, 1'b0);
        check("snooze4.ignored", int'(state), 1);
        keyCyc(1'b0, 1'b1, 1'b0);
        check("stop.state", int'(state), 0);

        // Stop wins over snooze; held match does not retrigger
        match = 1'b1;
        cyc();
        check("trigger3.state", int'(state), 1);
        tickCyc(2);
        keyCyc(1'b1, 1'b1, 1'b1);
        check("stop.wins", int'(state), 0);
        tickCyc(120);
        check("no.retrigger", int'(state), 0);
        match = 1'b0;
        cyc();
        match = 1'b1;
        cyc();
        check("trigger4.state", int'(state), 1);
        aEn = 1'b0;
        cyc();
        check("disable.state", int'(state), 0);
        aEn = 1'b1;
        match = 1'b0;
        cyc();

        // Hourly chime vectors
        mH = 4'd5;
        mL = 4'd9;
        for (int i = 0; i < 14; i++) begin
            sH = tbl[i].sh;
            sL = tbl[i].sl;
            tick = tbl[i].tk;
            cEn = tbl[i].ce;
            cyc();
            tick = 1'b0;
            check($sformatf("chime%0d.state", i), int'(state), tbl[i].st);
            check($sformatf("chime%0d.buzz", i), int'(buzz), tbl[i].bz);
            check($sformatf("chime%0d.tone", i), int'(tone), tbl[i].tn);
        end

        // Chime disable exit, then alarm preempting chime
        sH = 4'd5;
        sL = 4'd0;
        tickCyc(1);
        check("chime.enter", int'(state), 3);
        sL = 4'd3;
        cEn = 1'b0;
        cyc();
        check("chime.disable", int'(state), 0);
        cEn = 1'b1;
        sL = 4'd0;
        tickCyc(1);
        check("chime.reenter", int'(state), 3);
        sL = 4'd5;
        cyc();
        match = 1'b1;
        cyc();
        check("chime.preempt", int'(state), 1);
        tickCyc(3);
        check("ring.prereset.buzz", int'(buzz), 1);
        rst = 1'b1;
        modelReset();
        match = 1'b0;
        #1 checkZero("rst.async");
        @(posedge clk);
        #1 checkZero("rst.hold");
        rst = 1'b0;
        cEn = 1'b0;
        tickCyc(5);
        check("rst.idle", int'(state), 0);

        // Random traffic against the model
        for (int i = 0; i < 6000; i++) begin
            tick = ($urandom_range(0, 2) == 0);
            snz  = ($urandom_range(0, 150) == 0);
            stop = ($urandom_range(0, 1500) == 0);
            if (aEn) begin
                if ($urandom_range(0, 2000) == 0) aEn = 1'b0;
            end else if ($urandom_range(0, 19) == 0) begin
                aEn = 1'b1;
            end
            if ($urandom_range(0, 99) == 0) match = ~match;
            if ($urandom_range(0, 199) == 0) cEn = ~cEn;
            if ($urandom_range(0, 19) == 0) begin
                mH = 4'd5;
                mL = ($urandom_range(0, 3) == 0) ? 4'd8 : 4'd9;
                if ($urandom_range(0, 1) == 0) begin
                    sH = 4'd5;
                    sL = 4'd0;
                end else if ($urandom_range(0, 4) == 0) begin
                    sH = 4'd0;
                    sL = 4'd0;
                end else begin
                    sH = 4'd5;
                    sL = 4'($urandom_range(0, 9));
                end
            end
            cyc();
            tick = 1'b0;
            snz = 1'b0;
            stop = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
